// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the instruction-fetch slice.
//   INSTR_W          instruction word width
//   PC_INC           program counter step per instruction (bytes)
//   RESET_PC_DEFAULT default PC loaded on reset
//   fetch_state_t    fetch FSM encoding (FETCH issues reads, DRAIN drops stale responses)
package mips_pkg;

   localparam int          INSTR_W          = 32;
   localparam logic [31:0] PC_INC           = 32'd4;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic {
      FETCH = 1'b0,
      DRAIN = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: bundles the program-memory port, the redirect input and the
// IF/ID output port of the fetch stage.
//   imem_req_o/imem_addr_o     word read request issued this cycle
//   imem_rvalid_i/imem_rdata_i in-order read response, latency >= 1
//   redirect_i/redirect_pc_i   control transfer taken downstream
//   valid_o/ready_i            IF/ID handshake
//   instr_o/pc_plus_4_o        queue head payload
//   misalign_o                 one-cycle pulse for a misaligned redirect target
//
// Handshake: the IF/ID transfer happens in every cycle where valid_o and
// ready_i are both high at the rising edge. valid_o never depends on ready_i,
// and the payload is stable while valid_o is high and ready_i is low. The
// memory side has no back-pressure: a request is taken whenever imem_req_o is
// high, and every request is answered by exactly one imem_rvalid_i pulse.
interface fetch_stage_if;
   import mips_pkg::*;

   logic               imem_req_o;
   logic [31:0]        imem_addr_o;
   logic               imem_rvalid_i;
   logic [INSTR_W-1:0] imem_rdata_i;
   logic               redirect_i;
   logic [31:0]        redirect_pc_i;
   logic               valid_o;
   logic               ready_i;
   logic [INSTR_W-1:0] instr_o;
   logic [31:0]        pc_plus_4_o;
   logic               misalign_o;

   // Fetch stage side.
   modport master (
      output imem_req_o, imem_addr_o, valid_o, instr_o, pc_plus_4_o, misalign_o,
      input  imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, ready_i
   );

   // Environment side (program memory, PC select, IF/ID register).
   modport slave (
      input  imem_req_o, imem_addr_o, valid_o, instr_o, pc_plus_4_o, misalign_o,
      output imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, ready_i
   );

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered storage and combinational head.
//   clk, reset   rising-edge clock, synchronous active-high reset
//   push, din    write din when push is high (also allowed when full if popping)
//   pop          drop the head entry (ignored when empty)
//   flush        discard all entries; wins over push and pop
//   full, empty  occupancy flags
//   count        number of stored entries (0..DEPTH)
//   head         oldest entry, valid only while empty is low
// DEPTH must be a power of two and at least 2.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       din,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic [WIDTH-1:0]       head
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign count   = count_q;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: nothing is read until it has been written.
   always_ff @(posedge clk) begin
      if (do_push && !flush && !reset) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction fetch ahead of the IF/ID register.
// Owns the PC, issues word reads to program memory, buffers returned words in
// a prefetch queue and presents {pc_plus_4, instr} to IF/ID.
//   clk, reset  rising-edge clock, synchronous active-high reset
//   bus         fetch_stage_if.master: memory port, redirect, IF/ID port
//   dbg_state   current fetch FSM state
// A redirect flushes the queue and turns every read still in flight into a
// response to be dropped (DRAIN), so stale words never reach IF/ID.
module fetch_stage
   import mips_pkg::*;
#(
   parameter int          FIFO_DEPTH      = 4,
   parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic                clk,
   input  logic                reset,
   fetch_stage_if.master       bus,
   output fetch_state_t        dbg_state
);

   localparam int CW  = $clog2(FIFO_DEPTH) + 1;       // queue count width
   localparam int SCW = $clog2(MAX_OUTSTANDING) + 1;  // shadow count width
   localparam int OW  = $clog2(MAX_OUTSTANDING + 1);  // outstanding/discard width
   localparam int QW  = 32 + INSTR_W;                 // {pc_plus_4, instr}

   fetch_state_t       state_q, state_d;
   logic [31:0]        fetch_pc_q, fetch_pc_d;
   logic [OW-1:0]      outst_q, outst_d;
   logic [OW-1:0]      discard_q, discard_d;
   logic               misalign_q, misalign_d;
   logic [QW-1:0]      last_q;

   logic               rsp;
   logic               issue;
   logic               accept;
   logic               flush;
   logic               credit_ok;
   logic [CW:0]        credit_sum;

   logic               q_full, q_empty;
   logic [CW-1:0]      q_count;
   logic [QW-1:0]      q_head;
   logic [QW-1:0]      q_din;

   logic               sh_full, sh_empty;
   logic [SCW-1:0]     sh_count;
   logic [31:0]        sh_head;
   logic               unused_sh_count;

   assign unused_sh_count = ^sh_count;

   // A response with nothing in flight cannot belong to this stage (for
   // example one issued before reset), so it is ignored.
   assign rsp = bus.imem_rvalid_i && (outst_q != '0);

   // Every read in flight owns a queue slot, which is why a push can never
   // find the queue full.
   assign credit_sum = {1'b0, q_count} + (CW+1)'(outst_q);
   assign credit_ok  = (outst_q < OW'(MAX_OUTSTANDING))
                    && (credit_sum < (CW+1)'(FIFO_DEPTH))
                    && !q_full && !sh_full;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      outst_d    = outst_q;
      discard_d  = discard_q;
      misalign_d = 1'b0;
      issue      = 1'b0;
      accept     = 1'b0;
      flush      = 1'b0;
      if (bus.redirect_i) begin
         // Whatever is still in flight after this cycle is stale; a response
         // arriving right now is stale as well and is simply not pushed.
         flush      = 1'b1;
         fetch_pc_d = {bus.redirect_pc_i[31:2], 2'b00};
         misalign_d = |bus.redirect_pc_i[1:0];
         outst_d    = outst_q - OW'(rsp);
         discard_d  = outst_d;
         state_d    = (outst_d != '0) ? DRAIN : FETCH;
      end else begin
         unique case (state_q)
            FETCH: begin
               issue  = credit_ok;
               accept = rsp && (discard_q == '0) && !sh_empty;
               if (issue) fetch_pc_d = fetch_pc_q + PC_INC;
               outst_d = outst_q + OW'(issue) - OW'(rsp);
            end
            DRAIN: begin
               outst_d = outst_q - OW'(rsp);
               if (rsp && (discard_q != '0)) discard_d = discard_q - OW'(1);
               if (discard_d == '0) state_d = FETCH;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= FETCH;
         fetch_pc_q <= RESET_PC;
         outst_q    <= '0;
         discard_q  <= '0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         outst_q    <= outst_d;
         discard_q  <= discard_d;
         misalign_q <= misalign_d;
      end
   end

   // Last presented head, so the IF/ID payload holds while the queue is empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_q <= '0;
      end else if (!q_empty) begin
         last_q <= q_head;
      end
   end

   assign q_din = {sh_head + PC_INC, bus.imem_rdata_i};

   sync_fifo #(
      .WIDTH (QW),
      .DEPTH (FIFO_DEPTH)
   ) u_queue (
      .clk   (clk),
      .reset (reset),
      .push  (accept),
      .pop   (bus.valid_o && bus.ready_i),
      .flush (flush),
      .din   (q_din),
      .full  (q_full),
      .empty (q_empty),
      .count (q_count),
      .head  (q_head)
   );

   // Addresses of reads in flight, oldest first; responses return in order.
   sync_fifo #(
      .WIDTH (32),
      .DEPTH (MAX_OUTSTANDING)
   ) u_shadow (
      .clk   (clk),
      .reset (reset),
      .push  (issue),
      .pop   (accept),
      .flush (flush),
      .din   (fetch_pc_q),
      .full  (sh_full),
      .empty (sh_empty),
      .count (sh_count),
      .head  (sh_head)
   );

   assign bus.imem_req_o  = issue && !reset;
   assign bus.imem_addr_o = fetch_pc_q;
   assign bus.valid_o     = !q_empty;
   assign bus.instr_o     = q_empty ? last_q[INSTR_W-1:0] : q_head[INSTR_W-1:0];
   assign bus.pc_plus_4_o = q_empty ? last_q[QW-1:INSTR_W] : q_head[QW-1:INSTR_W];
   assign bus.misalign_o  = misalign_q;
   assign dbg_state       = state_q;

endmodule
